// File: rtl/aircon_pkg.sv
// Shared types and constants for the multi-zone heating/cooling controller.
package aircon_pkg;

  // Per-zone operating state; encoding is fixed so state values stay stable
  // across zones and tools.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } aircon_state_t;

  // Global mode selector values.
  localparam logic [1:0] MODE_AUTO      = 2'd0;
  localparam logic [1:0] MODE_HEAT_ONLY = 2'd1;
  localparam logic [1:0] MODE_COOL_ONLY = 2'd2;
  localparam logic [1:0] MODE_OFF       = 2'd3;

  // True when the global mode permits a zone to start heating.
  function automatic logic heat_allowed(input logic [1:0] mode_s);
    heat_allowed = (mode_s != MODE_COOL_ONLY) && (mode_s != MODE_OFF);
  endfunction

  // True when the global mode permits a zone to start cooling.
  function automatic logic cool_allowed(input logic [1:0] mode_s);
    cool_allowed = (mode_s != MODE_HEAT_ONLY) && (mode_s != MODE_OFF);
  endfunction

endpackage

// File: rtl/multi_zone_aircon_if.sv
// Sensor/actuator bundle between the sensor front end and the zone controller.
interface multi_zone_aircon_if #(
  parameter int ZONES  = 2,
  parameter int TEMP_W = 5
);

  logic [1:0]              mode;
  logic [ZONES*TEMP_W-1:0] temperature;
  logic [ZONES-1:0]        heating;
  logic [ZONES-1:0]        cooling;
  logic [ZONES-1:0]        dwell_lock;

  // Front end / supervisor side: supplies mode and readings, observes actuators.
  modport master (
    output mode,
    output temperature,
    input  heating,
    input  cooling,
    input  dwell_lock
  );

  // Controller side.
  modport slave (
    input  mode,
    input  temperature,
    output heating,
    output cooling,
    output dwell_lock
  );

endinterface

// File: rtl/aircon_zone_fsm.sv
// One climate zone: hysteresis FSM (IDLE/HEAT/COOL) with a minimum-dwell
// counter that blocks temperature-driven exits until the current state has
// been held long enough. Mode overrides bypass the dwell.
module aircon_zone_fsm
  import aircon_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] temp,
  output logic              heating,
  output logic              cooling,
  output logic              dwell_lock
);

  localparam int CNT_W = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MIN_DWELL);

  // Thresholds are compared at the sensor width, so they are resized once here.
  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);

  aircon_state_t    state_r;
  aircon_state_t    state_nxt_s;
  logic [CNT_W-1:0] dwell_cnt_r;
  logic [CNT_W-1:0] dwell_cnt_nxt_s;
  logic             dwell_ok_s;
  logic             heating_r;
  logic             cooling_r;
  logic             dwell_lock_r;

  assign dwell_ok_s = (dwell_cnt_r == DWELL_MAX);

  // Next-state selection: mode overrides first, then dwell-gated hysteresis.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (dwell_ok_s && (temp <= HEAT_ON_T) && heat_allowed(mode)) begin
          state_nxt_s = HEAT;
        end else if (dwell_ok_s && (temp >= COOL_ON_T) && cool_allowed(mode)) begin
          state_nxt_s = COOL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HEAT: begin
        if (!heat_allowed(mode)) begin
          state_nxt_s = IDLE;
        end else if (dwell_ok_s && (temp >= HEAT_OFF_T)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HEAT;
        end
      end
      COOL: begin
        if (!cool_allowed(mode)) begin
          state_nxt_s = IDLE;
        end else if (dwell_ok_s && (temp <= COOL_OFF_T)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = COOL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Dwell counter: restarts on any state change, otherwise saturates at the limit.
  always_comb begin
    dwell_cnt_nxt_s = dwell_cnt_r;
    if (state_nxt_s != state_r) begin
      dwell_cnt_nxt_s = '0;
    end else if (dwell_cnt_r < DWELL_MAX) begin
      dwell_cnt_nxt_s = dwell_cnt_r + CNT_W'(1);
    end else begin
      dwell_cnt_nxt_s = dwell_cnt_r;
    end
  end

  // State, counter and actuator registers; reset leaves the dwell satisfied
  // so the first transition after reset is not delayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      dwell_cnt_r  <= DWELL_MAX;
      heating_r    <= 1'b0;
      cooling_r    <= 1'b0;
      dwell_lock_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dwell_cnt_r  <= dwell_cnt_nxt_s;
      heating_r    <= (state_nxt_s == HEAT);
      cooling_r    <= (state_nxt_s == COOL);
      dwell_lock_r <= (dwell_cnt_nxt_s < DWELL_MAX);
    end
  end

  assign heating    = heating_r;
  assign cooling    = cooling_r;
  assign dwell_lock = dwell_lock_r;

endmodule

// File: rtl/multi_zone_aircon.sv
// Multi-zone climate controller: slices the packed sensor bus into per-zone
// readings and runs one independent zone FSM per sensor.
module multi_zone_aircon
  import aircon_pkg::*;
#(
  parameter int ZONES     = 2,
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_zone_aircon_if.slave   bus
);

  // Threshold ordering must leave a dead band between heating and cooling.
  if (ZONES < 1) begin : g_bad_zones
    $error("multi_zone_aircon: ZONES must be at least 1");
  end
  if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) && (COOL_OFF < COOL_ON))) begin : g_bad_thresholds
    $error("multi_zone_aircon: thresholds must satisfy HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON");
  end
  if (MIN_DWELL < 0) begin : g_bad_dwell
    $error("multi_zone_aircon: MIN_DWELL must not be negative");
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    aircon_zone_fsm #(
      .TEMP_W    (TEMP_W),
      .HEAT_ON   (HEAT_ON),
      .HEAT_OFF  (HEAT_OFF),
      .COOL_ON   (COOL_ON),
      .COOL_OFF  (COOL_OFF),
      .MIN_DWELL (MIN_DWELL)
    ) u_zone (
      .clk        (clk),
      .rst        (rst),
      .mode       (bus.mode),
      .temp       (bus.temperature[z*TEMP_W +: TEMP_W]),
      .heating    (bus.heating[z]),
      .cooling    (bus.cooling[z]),
      .dwell_lock (bus.dwell_lock[z])
    );
  end

endmodule
